// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW score path.
package dtw_pkg;

  localparam int DTW_WIDTH = 16;
  localparam logic [DTW_WIDTH-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } coll_state_t;

endpackage

// File: rtl/dtw_min_tracker.sv
// Running minimum of a cost stream with the index of its first occurrence.
module dtw_min_tracker
  import dtw_pkg::*;
#(
  parameter int width = DTW_WIDTH,
  parameter int IDXW  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             upd,
  input  logic [width-1:0] cost,
  input  logic [IDXW-1:0]  idx,
  output logic [width-1:0] min_cost,
  output logic [IDXW-1:0]  min_pos
);

  logic better;

  // strict compare: an equal cost later in the stream never displaces the earlier one
  assign better = cost < min_cost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_cost <= '1;
      min_pos  <= '0;
    end else if (clr) begin
      min_cost <= '1;
      min_pos  <= '0;
    end else if (upd && better) begin
      min_cost <= cost;
      min_pos  <= idx;
    end
  end

endmodule

// File: rtl/dtw_score_collector.sv
// Collects the last-PE DTW cost stream of one search and reports {min score, position}.
// Optional threshold hit flag: define DTW_SCORE_THRESH_EN.
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting costs, tracking minimum
// DONE  | result presented until res_ready
module dtw_score_collector
  import dtw_pkg::*;
#(
  parameter int width = DTW_WIDTH,
  parameter int IDXW  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDXW-1:0]  len,
  input  logic             in_valid,
  input  logic [width-1:0] in_cost,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [width-1:0] res_score,
  output logic [IDXW-1:0]  res_pos,
`ifdef DTW_SCORE_THRESH_EN
  input  logic [width-1:0] thresh,
  output logic             res_hit,
`endif
  output logic             busy
);

  coll_state_t state, state_nx;

  logic [IDXW-1:0] count;
  logic [IDXW-1:0] len_q;
  logic            xfer;
  logic            last;
  logic            clr;

  assign in_ready  = (state == ACCUM);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign xfer      = in_valid && in_ready;
  assign last      = (count == len_q - IDXW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr      = 1'b1;
          state_nx = (len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (xfer && last) state_nx = DONE;
      end
      DONE: begin
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      len_q <= '0;
    end else if (clr) begin
      count <= '0;
      len_q <= len;
    end else if (xfer) begin
      count <= count + IDXW'(1);
    end
  end

  dtw_min_tracker #(
    .width (width),
    .IDXW  (IDXW)
  ) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .upd      (xfer),
    .cost     (in_cost),
    .idx      (count),
    .min_cost (res_score),
    .min_pos  (res_pos)
  );

`ifdef DTW_SCORE_THRESH_EN
  logic [width-1:0] thresh_q;
  logic [width-1:0] min_next;

  // minimum including the sample being accepted on the final edge
  assign min_next = (in_cost < res_score) ? in_cost : res_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= '0;
      res_hit  <= 1'b0;
    end else if (clr) begin
      thresh_q <= thresh;
      res_hit  <= (len == '0) && (&thresh);
    end else if (xfer && last) begin
      res_hit  <= (min_next <= thresh_q);
    end
  end
`endif

endmodule

// File: tb/tb_dtw_score_collector.sv
// Self-checking bench for dtw_score_collector against a queue-based minimum model.
module tb_dtw_score_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [19:0] len;
  logic        in_valid;
  logic [15:0] in_cost;
  logic        in_ready;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_score;
  logic [19:0] res_pos;
  logic        busy;
`ifdef DTW_SCORE_THRESH_EN
  logic [15:0] thresh;
  logic        res_hit;
`endif

  int total = 0;
  int passed = 0;

  logic [15:0] cq[$];

  always #5 clk = ~clk;

  dtw_score_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_cost   (in_cost),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_score (res_score),
    .res_pos   (res_pos),
`ifdef DTW_SCORE_THRESH_EN
    .thresh    (thresh),
    .res_hit   (res_hit),
`endif
    .busy      (busy)
  );

  // minimum of the queued costs, first occurrence on ties; empty search yields all-ones/0
  function automatic void model(output logic [15:0] s, output logic [19:0] p);
    s = 16'hFFFF;
    p = '0;
    foreach (cq[i]) if (cq[i] < s) begin s = cq[i]; p = 20'(i); end
  endfunction

  task automatic send_start(input logic [19:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input bit gap, output bit to);
    int g;
    to = 1'b0;
    foreach (cq[i]) begin
      in_valid = 1'b1;
      in_cost  = cq[i];
      g = 0;
      while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
      if (!in_ready) begin to = 1'b1; in_valid = 1'b0; return; end
      @(posedge clk); #1;
      if (gap && i < cq.size() - 1) begin in_valid = 1'b0; @(posedge clk); #1; end
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready, res_valid, busy} !== 3'b000) $display("FAIL reset_flags got %b want 000", {in_ready, res_valid, busy});
    else passed++;
    total++;
    if (res_score !== 16'hFFFF || res_pos !== 20'd0) $display("FAIL reset_result got %h/%0d want ffff/0", res_score, res_pos);
    else passed++;
  endtask

  task automatic test_basic();
    logic [15:0] s; logic [19:0] p; bit to;
    cq = '{16'd9, 16'd4, 16'd7, 16'd4, 16'd6};
    model(s, p);
    send_start(20'd5);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL basic_accum got busy=%b in_ready=%b want 1 1", busy, in_ready);
    else passed++;
    feed(1'b0, to);
    total++;
    if (to || res_valid !== 1'b1) $display("FAIL basic_latency got res_valid=%b timeout=%0d want 1 0", res_valid, to);
    else passed++;
    total++;
    if (res_score !== s || res_pos !== p || s !== 16'd4 || p !== 20'd1) $display("FAIL basic_result got %0d/%0d want 4/1", res_score, res_pos);
    else passed++;
    handshake();
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_idle got res_valid=%b busy=%b want 0 0", res_valid, busy);
    else passed++;
  endtask

  task automatic test_empty();
    bit seen_ready = 1'b0;
    start = 1'b1; len = 20'd0;
    #1 seen_ready |= in_ready;
    @(posedge clk); #1;
    start = 1'b0;
    seen_ready |= in_ready;
    total++;
    if (res_valid !== 1'b1 || res_score !== 16'hFFFF || res_pos !== 20'd0) $display("FAIL empty_result got v=%b %h/%0d want 1 ffff/0", res_valid, res_score, res_pos);
    else passed++;
    repeat (2) begin @(posedge clk); #1; seen_ready |= in_ready; end
    total++;
    if (seen_ready !== 1'b0) $display("FAIL empty_in_ready got %b want 0", seen_ready);
    else passed++;
    handshake();
  endtask

  task automatic test_gaps_backpressure();
    logic [15:0] s; logic [19:0] p; bit to;
    cq = '{16'd8, 16'd3, 16'd3, 16'd1};
    model(s, p);
    send_start(20'd4);
    feed(1'b1, to);
    total++;
    if (to || res_valid !== 1'b1 || res_score !== 16'd1 || res_pos !== 20'd3 || s !== 16'd1)
      $display("FAIL gaps_result got v=%b %0d/%0d want 1 1/3", res_valid, res_score, res_pos);
    else passed++;
    in_valid = 1'b1; in_cost = 16'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++;
      if (res_valid !== 1'b1 || res_score !== s || res_pos !== p) $display("FAIL gaps_stable%0d got v=%b %0d/%0d want 1 %0d/%0d", k, res_valid, res_score, res_pos, s, p);
      else passed++;
    end
    in_valid = 1'b0;
    handshake();
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_score !== s || res_pos !== p) $display("FAIL gaps_after_hs got v=%b busy=%b %0d/%0d want 0 0 %0d/%0d", res_valid, busy, res_score, res_pos, s, p);
    else passed++;
  endtask

  task automatic test_start_ignored();
    logic [15:0] s; logic [19:0] p; bit to;
    send_start(20'd3);
    in_valid = 1'b1; in_cost = 16'd10;
    @(posedge clk); #1;
    start = 1'b1; len = 20'd1; in_cost = 16'd6;
    @(posedge clk); #1;
    start = 1'b0; in_cost = 16'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (res_valid !== 1'b1 || res_score !== 16'd6 || res_pos !== 20'd1) $display("FAIL ign_accum got v=%b %0d/%0d want 1 6/1", res_valid, res_score, res_pos);
    else passed++;
    start = 1'b1; len = 20'd0;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (res_valid !== 1'b1 || res_score !== 16'd6 || res_pos !== 20'd1) $display("FAIL ign_done got v=%b %0d/%0d want 1 6/1", res_valid, res_score, res_pos);
    else passed++;
    start = 1'b1; len = 20'd0; res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0) $display("FAIL ign_hs_start got busy=%b v=%b want 0 0", busy, res_valid);
    else passed++;
    cq = '{16'hFFF0, 16'hFFF5};
    model(s, p);
    send_start(20'd2);
    feed(1'b0, to);
    total++;
    if (to || res_valid !== 1'b1 || res_score !== s || res_pos !== p) $display("FAIL ign_fresh got v=%b %h/%0d want 1 %h/%0d", res_valid, res_score, res_pos, s, p);
    else passed++;
    handshake();
  endtask

  task automatic test_async_reset();
    logic [15:0] s; logic [19:0] p; bit to;
    send_start(20'd6);
    cq = '{16'd1, 16'd2};
    feed(1'b0, to);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, res_valid, busy} !== 3'b000 || res_score !== 16'hFFFF || res_pos !== 20'd0)
      $display("FAIL arst_values got flags=%b %h/%0d want 000 ffff/0", {in_ready, res_valid, busy}, res_score, res_pos);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cq = '{16'd5, 16'd2};
    model(s, p);
    send_start(20'd2);
    feed(1'b0, to);
    total++;
    if (to || res_valid !== 1'b1 || res_score !== 16'd2 || res_pos !== 20'd1 || s !== 16'd2)
      $display("FAIL arst_after got v=%b %0d/%0d want 1 2/1", res_valid, res_score, res_pos);
    else passed++;
    handshake();
  endtask

  task automatic test_random();
    logic [15:0] s; logic [19:0] p; bit to; int n; int d;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 12);
      cq = {};
      for (int i = 0; i < n; i++)
        cq.push_back(($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 20)));
      model(s, p);
      send_start(20'(n));
      feed(($urandom_range(0, 1) == 1), to);
      d = $urandom_range(0, 3);
      repeat (d) begin @(posedge clk); #1; end
      total++;
      if (to || res_valid !== 1'b1 || res_score !== s || res_pos !== p)
        $display("FAIL rand%0d got v=%b %0d/%0d want 1 %0d/%0d", t, res_valid, res_score, res_pos, s, p);
      else passed++;
      handshake();
    end
  endtask

`ifdef DTW_SCORE_THRESH_EN
  task automatic test_thresh();
    bit to;
    cq = '{16'd5, 16'd3};
    thresh = 16'd3;
    send_start(20'd2);
    feed(1'b0, to);
    total++;
    if (to || res_hit !== 1'b1) $display("FAIL thresh_hit got %b want 1", res_hit);
    else passed++;
    handshake();
    thresh = 16'd2;
    send_start(20'd2);
    feed(1'b0, to);
    total++;
    if (to || res_hit !== 1'b0) $display("FAIL thresh_miss got %b want 0", res_hit);
    else passed++;
    handshake();
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_cost = '0; res_ready = 1'b0;
`ifdef DTW_SCORE_THRESH_EN
    thresh = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_empty();
    test_gaps_backpressure();
    test_start_ignored();
    test_async_reset();
    test_random();
`ifdef DTW_SCORE_THRESH_EN
    test_thresh();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d of %0d checks", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
